// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment display controller: sequential binary-to-BCD conversion
// behind a valid/busy handshake, common-anode digit scanning, blanking, blink, overflow dashes.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 14,
  parameter int SCAN_DIV   = 100_000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     number,
  input  logic                  number_valid,
  output logic                  busy,
  output logic                  overflow,
  input  logic [NUM_DIGITS-1:0] dp,
  input  logic                  blank_en,
  input  logic                  blink_en,
  output logic [NUM_DIGITS-1:0] fndCom,
  output logic [7:0]            fndFont
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int SC_W  = $clog2(SCAN_DIV + 1);
  localparam int BC_W  = $clog2(BLINK_DIV + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  function automatic logic [63:0] max_value(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_value(NUM_DIGITS);

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] a);
    logic [BCD_W-1:0] r;
    r = a;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = a[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] font7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  acc_q, acc_d, acc_adj_s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              overflow_q, overflow_d;
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BC_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              scan_wrap_s;

  assign acc_adj_s = add3(acc_q);

  // Converter FSM: latch, shift-and-add-3 one bit per clock, then publish.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (number_valid) begin
          state_d    = S_SHIFT;
          bin_d      = number;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (64'(number) > MAX_VAL);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // bits pushed past the top nibble are dropped; overflow flag covers them
        acc_d = {acc_adj_s[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE: begin
        disp_d     = acc_q;
        overflow_d = ovf_pend_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Scan divider, digit index and blink phase.
  always_comb begin
    scan_wrap_s = (scan_cnt_q == SC_W'(SCAN_DIV - 1));
    scan_cnt_d  = scan_wrap_s ? '0 : scan_cnt_q + SC_W'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (scan_wrap_s) begin
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (scan_wrap_s) begin
      if (blink_cnt_q == BC_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
        phase_d     = phase_q;
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      disp_q      <= '0;
      overflow_q  <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      disp_q      <= disp_d;
      overflow_q  <= overflow_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  logic [BCD_W-1:0]      upper_s;
  logic [3:0]            nib_s;
  logic                  blanked_s;
  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] sel_s;

  // Digit select and segment decode from registered state plus live controls.
  always_comb begin
    upper_s   = disp_q >> {idx_q, 2'b00};
    nib_s     = disp_q[{idx_q, 2'b00} +: 4];
    blanked_s = blank_en && (idx_q != '0) && (upper_s == '0);
    sel_s     = NUM_DIGITS'(1) << idx_q;
    if (overflow_q) begin
      seg_s = 7'h3F;
    end else if (blanked_s) begin
      seg_s = 7'h7F;
    end else begin
      seg_s = font7(nib_s);
    end
    if (blink_en && phase_q) begin
      fndCom = '1;
    end else begin
      fndCom = ~sel_s;
    end
    fndFont = {~dp[idx_q], seg_s};
  end

  assign busy     = (state_q != S_IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: vector table, hand sequences for reset,
// drop, blink corners, and a randomized phase against an arithmetic reference model.
module tb_fnd_scan_ctrl;

  localparam int ND  = 4;
  localparam int DW  = 14;
  localparam int SD  = 4;
  localparam int BD  = 2;
  localparam int P10 = 10000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] number = '0;
  logic          number_valid = 1'b0;
  logic          busy;
  logic          overflow;
  logic [ND-1:0] dp = '0;
  logic          blank_en = 1'b0;
  logic          blink_en = 1'b0;
  logic [ND-1:0] fndCom;
  logic [7:0]    fndFont;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  fnd_scan_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .number(number), .number_valid(number_valid),
    .busy(busy), .overflow(overflow), .dp(dp), .blank_en(blank_en),
    .blink_en(blink_en), .fndCom(fndCom), .fndFont(fndFont)
  );

  always #5 clk = ~clk;

  // Reference model: cycle count since reset, remaining conversion latency, shown value.
  int cyc_m = 0, cd_m = 0, pend_m = 0, disp_m = 0, steps_m = 0;
  bit ovf_m = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_m <= 0; cd_m <= 0; disp_m <= 0; ovf_m <= 1'b0; steps_m <= 0;
    end else begin
      cyc_m <= cyc_m + 1;
      if (!blink_en) steps_m <= 0;
      else if ((cyc_m % SD) == SD - 1) steps_m <= steps_m + 1;
      if (cd_m == 0) begin
        if (number_valid) begin
          cd_m   <= DW + 1;
          pend_m <= int'(number);
        end
      end else begin
        cd_m <= cd_m - 1;
        if (cd_m == 1) begin
          disp_m <= pend_m % P10;
          ovf_m  <= (pend_m > P10 - 1);
        end
      end
    end
  end

  function automatic int idx_m();
    return (cyc_m / SD) % ND;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [ND-1:0] exp_com();
    if (blink_en && (((steps_m / BD) % 2) == 1)) return '1;
    return ~(ND'(1) << idx_m());
  endfunction

  function automatic logic [7:0] exp_font();
    int idx, p;
    logic [6:0] seg;
    idx = idx_m();
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ovf_m) seg = 7'h3F;
    else if (blank_en && idx > 0 && (disp_m / p) == 0) seg = 7'h7F;
    else seg = seg_of((disp_m / p) % 10);
    return {~dp[idx], seg};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      chk("model_com", 32'(fndCom), 32'(exp_com()));
      chk("model_font", 32'(fndFont), 32'(exp_font()));
      chk("model_busy", 32'(busy), 32'(cd_m != 0));
      chk("model_ovf", 32'(overflow), 32'(ovf_m));
    end
  endtask

  task automatic send(input int v, output int nbusy);
    for (int k = 0; k < 40 && busy; k++) step();
    number = DW'(v);
    number_valid = 1'b1;
    step();
    number_valid = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 40) begin
      nbusy++;
      step();
    end
  endtask

  task automatic show_digit(input int i, input logic [7:0] expf, input string nm);
    logic [ND-1:0] sel;
    sel = ~(ND'(1) << i);
    for (int k = 0; k < 40 && fndCom !== sel; k++) step();
    chk({nm, "_sel"}, 32'(fndCom), 32'(sel));
    chk(nm, 32'(fndFont), 32'(expf));
  endtask

  typedef struct {
    int             value;
    logic           blank;
    logic [3:0]     dpv;
    logic           ovf;
    logic [3:0][7:0] f;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int nb, n;
    vecs[0] = '{1234,  1'b0, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = '{7,     1'b1, 4'b0010, 1'b0, {8'hFF, 8'hFF, 8'h7F, 8'hF8}};
    vecs[2] = '{12000, 1'b0, 4'b0000, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[3] = '{42,    1'b0, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'h99, 8'hA4}};
    vecs[4] = '{0,     1'b1, 4'b0000, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[5] = '{9999,  1'b1, 4'b1111, 1'b0, {8'h10, 8'h10, 8'h10, 8'h10}};
    vecs[6] = '{10000, 1'b1, 4'b0001, 1'b1, {8'hBF, 8'hBF, 8'hBF, 8'h3F}};
    vecs[7] = '{305,   1'b1, 4'b0000, 1'b0, {8'hFF, 8'hB0, 8'hC0, 8'h92}};
    vecs[8] = '{16383, 1'b0, 4'b1000, 1'b1, {8'h3F, 8'hBF, 8'hBF, 8'hBF}};

    // reset state and scan timing
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_com", 32'(fndCom), 32'hE);
    chk("rst_font", 32'(fndFont), 32'hC0);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rel_com", 32'(fndCom), 32'hE);
    chk("rel_ovf", 32'(overflow), 32'd0);
    repeat (4) step();
    chk("scan_step1", 32'(fndCom), 32'hD);
    repeat (12) step();
    chk("scan_wrap", 32'(fndCom), 32'hE);

    // table-driven conversions
    for (int v = 0; v < 9; v++) begin
      blank_en = vecs[v].blank;
      dp = vecs[v].dpv;
      send(vecs[v].value, nb);
      chk("busy_len", 32'(nb), 32'(DW + 1));
      chk("vec_ovf", 32'(overflow), 32'(vecs[v].ovf));
      for (int i = 0; i < ND; i++) show_digit(i, vecs[v].f[i], "vec_font");
    end

    // second request during busy is dropped
    blank_en = 1'b0;
    dp = '0;
    number = DW'(100);
    number_valid = 1'b1;
    step();
    number_valid = 1'b0;
    repeat (4) step();
    number = DW'(200);
    number_valid = 1'b1;
    step();
    number_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) step();
    chk("drop_busy", 32'(busy), 32'd0);
    show_digit(0, 8'hC0, "drop_d0");
    show_digit(1, 8'hC0, "drop_d1");
    show_digit(2, 8'hF9, "drop_d2");

    // reset mid-conversion aborts and clears at once
    send(555, nb);
    number = DW'(987);
    number_valid = 1'b1;
    step();
    number_valid = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_font", 32'(fndFont), 32'hC0);
    chk("abort_com", 32'(fndCom), 32'hE);
    repeat (2) step();
    reset = 1'b0;
    repeat (4) step();

    // blink: 8 clocks dark, 8 clocks scanning, immediate restore on disable
    blink_en = 1'b1;
    for (int k = 0; k < 40 && fndCom !== 4'hF; k++) step();
    chk("blink_dark", 32'(fndCom), 32'hF);
    n = 0;
    while (fndCom === 4'hF && n < 20) begin n++; step(); end
    chk("blink_dark_len", 32'(n), 32'd8);
    n = 0;
    while (fndCom !== 4'hF && n < 20) begin n++; step(); end
    chk("blink_lit_len", 32'(n), 32'd8);
    blink_en = 1'b0;
    #1;
    chk("blink_off", 32'(fndCom), 32'(exp_com()));
    step();

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      dp = ND'($urandom);
      blank_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      number_valid = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 5))
        0: number = DW'(0);
        1: number = DW'(9999);
        2: number = DW'(10000);
        3: number = '1;
        4: number = DW'($urandom_range(0, 99));
        default: number = DW'($urandom);
      endcase
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
# fnd_scan_ctrl

Parametrised multiplexed 7-segment (FND) display controller that succeeds the fixed 4-digit, 8-bit driver. It accepts a binary value through a valid/busy handshake and converts it to BCD sequentially (shift-and-add-3, one bit per clock). It then scans NUM_DIGITS common-anode digits with optional leading-zero blanking, per-digit decimal points, blink and overflow indication. It sits on the APB FND peripheral between the register bank and the board pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8, need not be a power of two)
- DATA_W, 14, width of the binary input value
- SCAN_DIV, 100_000, clocks per digit-scan step (1 kHz at 100 MHz)
- BLINK_DIV, 250, scan steps per blink half-period
- clk  input  1  system clock; everything sampled on rising edge
- reset  input  1  asynchronous, active-high reset
- number  input  DATA_W  binary value to display
- number_valid  input  1  request to load `number`
- busy  output  1  conversion in progress; `number_valid` ignored while high
- overflow  output  1  last accepted value exceeded 10^NUM_DIGITS−1
- dp  input  NUM_DIGITS  decimal point per digit, 1 = lit, used live
- blank_en  input  1  leading-zero blanking enable, used live
- blink_en  input  1  blink enable, used live
- fndCom  output  NUM_DIGITS  digit select, active-low one-hot
- fndFont  output  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
- Reset: `busy`=0, `overflow`=0, display BCD register=0, scan index=0, blink phase=0, `fndCom`=~1 (digit 0 on), `fndFont`=8'hC0 when dp[0]=0.
- Converter FSM has three states:
  - IDLE: on `number_valid` && !`busy`, latch `number`, clear BCD accumulator, clear bit counter, record overflow (`number` > 10^NUM_DIGITS−1), go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift left one bit, MSB of number first. After DATA_W shifts, go to DONE.
  - DONE: copy accumulator to the display register, update `overflow`, return to IDLE.
- `busy` is high in SHIFT and DONE. A valid request during busy is dropped, not queued.
- Accumulator width is 4·NUM_DIGITS. Bits shifted past the top nibble are discarded; the overflow flag covers that case.
- Scan: the divider counts 0..SCAN_DIV−1. On the wrap edge, the scan index advances. It wraps from NUM_DIGITS−1 to 0.
- Digit font comes from the display nibble at the scan index through the standard 0–F table (0=C0, 1=F9, … 9=90, A=88 … F=8E), with bit7 = ~dp[index].
- Leading-zero blanking: when `blank_en`=1, digit i>0 is blanked if nibbles i..NUM_DIGITS−1 are all zero. A blanked digit drives segments 7'h7F; its dp bit is still honoured. Digit 0 is never blanked.
- Overflow display: while `overflow`=1, every digit shows a dash (segments 7'h3F, g only) plus its dp. Blanking is not applied.
- Blink: a phase counter counts scan steps and toggles the phase every BLINK_DIV steps. When `blink_en`=1 and phase=1, `fndCom`=all ones. `blink_en`=0 clears the phase and its counter.
- `fndCom` and `fndFont` are combinational from registered state: index, display register, overflow, phase and the live inputs.

## Timing
- Valid accepted at edge N: `busy`=1 from N. Shifts occur on edges N+1..N+DATA_W. The display register and `overflow` update at edge N+DATA_W+1, and `busy`=0 from that same edge. A new value can be accepted at edge N+DATA_W+2.
- The displayed digit changes in the same cycle as the display register update; there is no extra pipeline stage.
- After reset release, the scan index becomes 1 at the SCAN_DIV-th rising edge. Each digit is active for exactly SCAN_DIV cycles.
- Reset asserted mid-conversion aborts it. The display returns to 0 and `busy` clears immediately (asynchronous).
- `dp`, `blank_en` and `blink_en` changes take effect combinationally on the next output evaluation.
- If a blink phase toggle and a scan wrap coincide, both apply on the same edge.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=2, NUM_DIGITS=4, DATA_W=14.
- Reset check: hold reset, then release -> `fndCom`=4'b1110, `fndFont`=8'hC0, `busy`=0. `fndCom`=4'b1101 after 4 clocks; wraps back to 4'b1110 after 16 clocks.
- Conversion of 1234 -> `busy` high for 15 cycles. Afterwards the scan shows digit0=8'h99, digit1=8'hB0, digit2=8'hA4, digit3=8'hF9.
- Value 7 with blank_en=1 and dp=4'b0010 -> digit0=8'hF8, digit1=8'h7F, digit2=8'hFF, digit3=8'hFF.
- Value 12000 (> 9999) -> `overflow`=1 and all digits 8'hBF. Then value 42 -> `overflow`=0, digit1=8'h99, digit0=8'hA4.
- Valid pulses at cycles 0 and 5 with 100 then 200 -> only 100 is displayed; the second pulse is dropped. Reset asserted mid-conversion -> display 0, `busy`=0.
- blink_en=1 -> `fndCom`=4'b1111 for 8 clocks, then normal scanning for 8 clocks, repeating. Clearing blink_en restores scanning immediately.
